// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_pkg;

  localparam int DEF_COUNT_RAM_WORD = 1024;
  localparam int DEF_SIZE_WORD      = 32;
  localparam int STRB_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// Contents are intentionally not reset.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [WIDTH/8-1:0]   we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // One access per enabled cycle: byte-lane writes plus read of the old word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits WAIT_STATES
// cycles, then performs the array access and holds the response until taken.
// Optional MEM_RESPONDER_ERR_EN: flags out-of-range or misaligned addresses.
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | request captured, counting down wait states
// RESP    | response valid, holding until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int COUNT_RAM_WORD = DEF_COUNT_RAM_WORD,
  parameter int SIZE_WORD      = DEF_SIZE_WORD,
  parameter int WAIT_STATES    = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(COUNT_RAM_WORD);
  localparam logic [3:0] WAIT_CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_load_q;

  logic              accept;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [STRB_W-1:0] acc_wstrb;
  logic              acc_err;
  logic              enter_resp;
  logic              ram_en;
  logic [STRB_W-1:0] ram_we;
  logic [SIZE_WORD-1:0] ram_rdata;

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the access happens on the accepting edge, so the
  // live request drives the array; otherwise the captured copy does.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    if (state_q == ST_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wstrb = bus.req_wstrb;
    end
  end

  // Marks the edge that moves the FSM into RESP.
  always_comb begin
    enter_resp = 1'b0;
    if (state_q == ST_IDLE)      enter_resp = accept && (WAIT_STATES == 0);
    else if (state_q == ST_WAIT) enter_resp = (cnt_q == 4'd0);
  end

`ifdef MEM_RESPONDER_ERR_EN
  assign acc_err = (acc_addr >= 32'(4 * COUNT_RAM_WORD)) || (acc_addr[1:0] != 2'b00);
`else
  assign acc_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

  assign ram_en = enter_resp && !acc_err;
  assign ram_we = (ram_en && acc_we) ? acc_wstrb : '0;

  mem_array #(
    .DEPTH (COUNT_RAM_WORD),
    .WIDTH (SIZE_WORD),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // Control FSM, wait counter, request capture and registered response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            cnt_q   <= WAIT_CNT_INIT;
            state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_load_q  <= !acc_we && !acc_err;
      end else if (state_q == ST_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_load_q  <= 1'b0;
      end
    end
  end

  // Loads expose the array's registered read; stores and errors read as zero.
  assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: one responder with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_responder_if bus1 ();
  mem_responder_if bus0 ();

  mem_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [31:0] model1 [1024];
  logic [31:0] model0 [1024];
  logic [32:0] sb1 [$];
  logic [32:0] sb0 [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  req_t reqs [9];

  function automatic logic exp_err(input logic [31:0] a);
`ifdef MEM_RESPONDER_ERR_EN
    return (a >= 32'h1000) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One transaction on the WAIT_STATES=1 responder; hold>0 stalls rsp_ready.
  task automatic txn1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int hold);
    int cyc;
    int lat;
    int ix;
    logic [31:0] held;
    logic [32:0] e;
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    bus1.req_wstrb = strb;
    bus1.rsp_ready = (hold == 0);
    cyc = 0;
    while (!bus1.req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!bus1.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, bus1.req_ready);
      bus1.req_valid = 1'b0;
      bus1.rsp_ready = 1'b1;
      return;
    end
    ix = int'(addr[11:2]);
    if (exp_err(addr)) sb1.push_back({1'b1, 32'h0});
    else if (we) begin
      model1[ix] = merge(model1[ix], wdata, strb);
      sb1.push_back({1'b0, 32'h0});
    end else sb1.push_back({1'b0, model1[ix]});
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'($urandom);
    bus1.req_addr  = $urandom;
    bus1.req_wdata = $urandom;
    bus1.req_wstrb = 4'($urandom);
    lat = 1;
    while (!bus1.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL latency addr=%h got=%0d cycles required 2", addr, lat);
    end
    if (!bus1.rsp_valid) begin bus1.rsp_ready = 1'b1; return; end
    e = sb1.pop_front();
    total++;
    if (bus1.rsp_rdata !== e[31:0]) begin
      bad++;
      $display("FAIL rdata addr=%h got=%h required %h", addr, bus1.rsp_rdata, e[31:0]);
    end
    total++;
    if (bus1.rsp_err !== e[32]) begin
      bad++;
      $display("FAIL err addr=%h got=%b required %b", addr, bus1.rsp_err, e[32]);
    end
    if (hold > 0) begin
      held = bus1.rsp_rdata;
      bus1.req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        total++;
        if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== held || bus1.req_ready !== 1'b0) begin
          bad++;
          $display("FAIL backpressure cyc=%0d valid=%b rdata=%h ready=%b required 1 %h 0",
                   i, bus1.rsp_valid, bus1.rsp_rdata, bus1.req_ready, held);
        end
      end
      bus1.req_valid = 1'b0;
      bus1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin
        bad++;
        $display("FAIL release valid=%b ready=%b required 0 1", bus1.rsp_valid, bus1.req_ready);
      end
    end else begin
      @(posedge clk); #1;
      total++;
      if (bus1.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rsp_drop addr=%h rsp_valid=%b required 0", addr, bus1.rsp_valid);
      end
    end
    bus1.rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err} !== 35'h0) begin
      bad++;
      $display("FAIL reset1 ready=%b valid=%b rdata=%h err=%b required all 0",
               bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
    end
    total++;
    if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err} !== 35'h0) begin
      bad++;
      $display("FAIL reset0 ready=%b valid=%b rdata=%h err=%b required all 0",
               bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus1.req_ready !== 1'b1 || bus0.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release ready1=%b ready0=%b required 1 1",
               bus1.req_ready, bus0.req_ready);
    end
  endtask

  task automatic test_store_load();
    txn1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn1(1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_partial_store();
    txn1(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn1(1'b1, 32'h20, 32'h000000AA, 4'h1, 0);
    txn1(1'b0, 32'h20, 32'h0, 4'hF, 0);
    txn1(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
    txn1(1'b0, 32'h20, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure();
    txn1(1'b0, 32'h10, 32'h0, 4'h0, 5);
  endtask

  task automatic drive0(input int i);
    bus0.req_we    = reqs[i].we;
    bus0.req_addr  = reqs[i].addr;
    bus0.req_wdata = reqs[i].wdata;
    bus0.req_wstrb = reqs[i].strb;
    bus0.req_valid = 1'b1;
  endtask

  // Streams requests at the zero-wait responder with rsp_ready held high.
  task automatic test_back_to_back();
    int idx;
    int acc_prev;
    int ix;
    logic acc;
    logic [32:0] e;
    reqs[0] = '{1'b1, 32'h0, 32'h01020304, 4'hF};
    reqs[1] = '{1'b1, 32'h4, 32'hA5A5A5A5, 4'hF};
    reqs[2] = '{1'b1, 32'h8, 32'h12345678, 4'hF};
    reqs[3] = '{1'b1, 32'h8, 32'h0000BB00, 4'h2};
    reqs[4] = '{1'b1, 32'hC, 32'h00000099, 4'h0};
    reqs[5] = '{1'b0, 32'h0, 32'h0, 4'h0};
    reqs[6] = '{1'b0, 32'h4, 32'h0, 4'h0};
    reqs[7] = '{1'b0, 32'h8, 32'h0, 4'hF};
    reqs[8] = '{1'b0, 32'h0, 32'h0, 4'h0};
    bus0.rsp_ready = 1'b1;
    idx = 0;
    acc_prev = -100;
    drive0(0);
    for (int c = 0; c < 80; c++) begin
      if (idx >= 9 && sb0.size() == 0) break;
      @(negedge clk);
      acc = 1'b0;
      if (bus0.rsp_valid) begin
        total++;
        if (sb0.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected_rsp cyc=%0d rdata=%h required no response", c, bus0.rsp_rdata);
        end else begin
          e = sb0.pop_front();
          if (bus0.rsp_rdata !== e[31:0] || bus0.rsp_err !== e[32]) begin
            bad++;
            $display("FAIL b2b_rsp cyc=%0d got=%h/%b required %h/%b",
                     c, bus0.rsp_rdata, bus0.rsp_err, e[31:0], e[32]);
          end
          total++;
          if (c != acc_prev + 1) begin
            bad++;
            $display("FAIL b2b_rsp_latency cyc=%0d got=%0d required 1", c, c - acc_prev);
          end
        end
      end
      if (bus0.req_valid && bus0.req_ready) begin
        if (idx > 0) begin
          total++;
          if (c - acc_prev != 2) begin
            bad++;
            $display("FAIL b2b_spacing req=%0d got=%0d required 2", idx, c - acc_prev);
          end
        end
        ix = int'(bus0.req_addr[11:2]);
        if (exp_err(bus0.req_addr)) sb0.push_back({1'b1, 32'h0});
        else if (bus0.req_we) begin
          model0[ix] = merge(model0[ix], bus0.req_wdata, bus0.req_wstrb);
          sb0.push_back({1'b0, 32'h0});
        end else sb0.push_back({1'b0, model0[ix]});
        acc_prev = c;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 9) drive0(idx);
        else bus0.req_valid = 1'b0;
      end
    end
    bus0.req_valid = 1'b0;
    total++;
    if (idx != 9 || sb0.size() != 0) begin
      bad++;
      $display("FAIL b2b_incomplete accepted=%0d pending=%0d required 9 0", idx, sb0.size());
    end
  endtask

  task automatic test_reset_mid();
    txn1(1'b1, 32'h40, 32'h0, 4'hF, 0);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b1;
    bus1.req_addr  = 32'h40;
    bus1.req_wdata = 32'hCAFEF00D;
    bus1.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset valid=%b ready=%b required 0 0", bus1.rsp_valid, bus1.req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus1.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_norsp cyc=%0d rsp_valid=%b required 0", i, bus1.rsp_valid);
      end
    end
    txn1(1'b0, 32'h40, 32'h0, 4'h0, 0);
  endtask

  task automatic test_addr_range();
    txn1(1'b1, 32'h0, 32'h5A5A0001, 4'hF, 0);
    txn1(1'b0, 32'h1000, 32'h0, 4'h0, 0);
    txn1(1'b0, 32'h1002, 32'h0, 4'h0, 0);
    txn1(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0);
    txn1(1'b0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  initial begin
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_wstrb = '0; bus1.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0;   bus0.req_wstrb = '0; bus0.rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_partial_store();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_addr_range();
    total++;
    if (sb1.size() != 0) begin
      bad++;
      $display("FAIL sb1_leftover pending=%0d required 0", sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
